csa_serial_adder: RTL and testbench

- Multi-cycle WIDTH-bit adder that consumes one 4-bit carry-select slice per clock.
- Each cycle it computes both candidate nibble sums, carry-in 0 and carry-in 1. A 4-bit 2:1 mux stage picks one, with the registered carry as the select.
- The block collects the selected nibbles into the result register.
- It sits between the operand source and any consumer that needs a full-width sum with valid/ready handshakes, trading latency for the area of a single 4-bit slice.

---
 rtl/csa_serial_adder.sv | 145 ++++++++++++++
 tb/tb_csa_serial_adder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/csa_serial_adder.sv
// Multi-cycle carry-select adder: one 4-bit slice per clock, N = WIDTH/4 cycles per sum.
// Optional signed-overflow output enabled by defining CSA_OVF_EN.
module csa_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CSA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned N    = WIDTH / 4;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_width_check
    $error("csa_serial_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  // Bit offset of the nibble handled this cycle.
  logic [IdxW+1:0]  base;
  logic [3:0]       a_nib, b_nib;
  logic [4:0]       s0, s1, pick;

  assign base  = {idx_q, 2'b00};
  assign a_nib = a_q[base +: 4];
  assign b_nib = b_q[base +: 4];
  assign s0    = {1'b0, a_nib} + {1'b0, b_nib};
  assign s1    = s0 + 5'd1;
  assign pick  = carry_q ? s1 : s0;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[base +: 4] = pick[3:0];
        carry_d          = pick[4];
        if (idx_q == LastIdx) begin
          cout_d  = pick[4];
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

`ifdef CSA_OVF_EN
  logic ovf_q, ovf_d;
  logic carry_msb;

  // Carry into the top bit recovered from the top sum bit of the last slice.
  assign carry_msb = pick[3] ^ a_nib[3] ^ b_nib[3];

  always_comb begin
    ovf_d = ovf_q;
    if ((state_q == StRun) && (idx_q == LastIdx)) begin
      ovf_d = carry_msb ^ pick[4];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_csa_serial_adder.sv
// Scoreboard bench for csa_serial_adder: directed plan cases plus randomized operands.
module tb_csa_serial_adder;
  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
`ifdef CSA_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;
  bit rnd_ready = 1'b0;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t q[$];

  csa_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef CSA_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: plain integer addition, signed overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    logic [W:0] t;
    exp_t e;
    t   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    e.s = t[W-1:0];
    e.c = t[W];
    e.o = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return e;
  endfunction

  // Monitor: compares on every output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_output", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sum", 64'(sum), 64'(e.s));
        check("cout", 64'(cout), 64'(e.c));
`ifdef CSA_OVF_EN
        check("ovf", 64'(ovf), 64'(e.o));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                       input bit push);
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) check("accept_timeout", 64'd0, 64'd1);
    a        = x;
    b        = y;
    cin      = ci;
    in_valid = 1'b1;
    if (push) q.push_back(model(x, y, ci));
    tick();
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    cin      = 1'($urandom_range(0, 1));
  endtask

  // Waits for out_valid, checks latency and busy in_ready, holds for `hold` cycles, then handshakes.
  task automatic finish_op(input int hold);
    int n = 0;
    bit ir_seen;
    logic [W-1:0] s_keep;
    logic c_keep;
    ir_seen = in_ready;
    while (!out_valid && n < 3 * N) begin
      tick();
      n++;
      if (!out_valid) ir_seen |= in_ready;
    end
    check("latency", 64'(n), 64'(N));
    check("busy_in_ready", 64'(ir_seen), 64'd0);
    s_keep = sum;
    c_keep = cout;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a        = W'($urandom);
      b        = W'($urandom);
      tick();
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_sum", 64'(sum), 64'(s_keep));
      check("hold_cout", 64'(cout), 64'(c_keep));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("post_hs_out_valid", 64'(out_valid), 64'd0);
    check("post_hs_in_ready", 64'(in_ready), 64'd1);
    check("post_hs_sum_kept", 64'(sum), 64'(s_keep));
    out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [W-1:0] x, y;

    rst_n = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
`ifdef CSA_OVF_EN
    check("rst_ovf", 64'(ovf), 64'd0);
`endif
    rst_n = 1'b1;
    tick();

    issue(16'h1234, 16'h4321, 1'b0, 1'b1);
    finish_op(0);
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b1);
    finish_op(0);
    issue(16'h0000, 16'h0000, 1'b1, 1'b1);
    finish_op(0);
    issue(16'hABCD, 16'h5432, 1'b1, 1'b1);
    finish_op(5);

    // Reset lands on the second RUN edge; the in-flight op is dropped.
    issue(16'h1111, 16'h2222, 1'b1, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_sum", 64'(sum), 64'd0);
    check("midrst_cout", 64'(cout), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    issue(16'h00FF, 16'h0001, 1'b0, 1'b1);
    finish_op(0);

`ifdef CSA_OVF_EN
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b1);
    finish_op(0);
    issue(16'h8000, 16'h8000, 1'b0, 1'b1);
    finish_op(0);
    issue(16'h1234, 16'h4321, 1'b0, 1'b1);
    finish_op(0);
`endif

    rnd_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: x = '1;
        1: x = {1'b0, {(W-1){1'b1}}};
        default: x = W'($urandom);
      endcase
      y = ($urandom_range(0, 4) == 0) ? W'(1) : W'($urandom);
      issue(x, y, 1'($urandom_range(0, 1)), 1'b1);
      repeat ($urandom_range(0, 3)) tick();
    end
    n = 0;
    while (q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    rnd_ready = 1'b0;
    out_ready = 1'b0;
    check("drain_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
